// File: rtl/demux_pkg.sv
// Shared widths and types for the 1-to-4 demux feeder and its channel picker.
package demux_pkg;

  localparam int DATA_W = 4;
  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef logic [SEL_W-1:0]  sel_t;
  typedef logic [DATA_W-1:0] data_t;

endpackage

// File: rtl/demux1to4_rr_pick.sv
// Cyclic first-set search over a 4-bit channel mask, starting at 'start'.
// Purely combinational (zero latency); no handshake of its own.
module demux1to4_rr_pick
  import demux_pkg::*;
(
  input  sel_t              start,
  input  logic [NUM_CH-1:0] mask,
  output sel_t              pick,
  output logic              any
);

  sel_t idx;
  logic found;

  // Walk start, start+1, ... with natural 2-bit wrap; first enabled channel wins.
  always_comb begin
    pick  = start;
    idx   = start;
    found = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = start + sel_t'(k);
      if (!found && mask[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  assign any = |mask;

endmodule

// File: rtl/demux1to4_dispatcher.sv
// Round-robin word-to-channel dispatcher feeding the 1-to-4 demux; one-entry output register.
// Accept-to-out_valid latency 1 cycle; input stalls while the held pair is blocked or all channels are masked.
module demux1to4_dispatcher
  import demux_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  data_t             in_data,
  input  logic              in_sof,
  input  logic [NUM_CH-1:0] ch_mask,
  output logic              out_valid,
  input  logic              out_ready,
  output sel_t              out_sel,
  output data_t             out_d,
  output sel_t              ptr_o
);

  sel_t  ptr_q;
  sel_t  sel_q;
  data_t word_q;
  logic  vld_q;

  sel_t  start;
  sel_t  target;
  logic  mask_any;
  logic  accept;

  assign start = in_sof ? sel_t'(0) : ptr_q;

  demux1to4_rr_pick u_pick (
    .start (start),
    .mask  (ch_mask),
    .pick  (target),
    .any   (mask_any)
  );

  // Draining and refilling in the same cycle keeps full throughput.
  assign in_ready = !rst && mask_any && (!vld_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= 1'b0;
      sel_q  <= '0;
      word_q <= '0;
      ptr_q  <= '0;
    end else if (accept) begin
      vld_q  <= 1'b1;
      sel_q  <= target;
      word_q <= in_data;
      ptr_q  <= target + sel_t'(1);
    end else if (out_ready) begin
      vld_q  <= 1'b0;
    end
  end

  // Data is gated so the demux never sees a stale word while idle.
  assign out_valid = vld_q;
  assign out_sel   = sel_q;
  assign out_d     = vld_q ? word_q : '0;
  assign ptr_o     = ptr_q;

endmodule
